// File: rtl/win_addr_pkg.sv
// win_addr_pkg -- shared types and dimension helpers for the window address
// generator.
//   state_t   : scan FSM state encoding (IDLE, RUN, DONE)
//   out_dim   : number of window positions along one axis
//   lane_base : first-pixel offset of the row band owned by a lane
//   cnt_w     : register width for a counter that runs 0..max-1
package win_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic int lane_base(input int lane, input int rows,
                                   input int stride, input int img_w);
    return lane * rows * stride * img_w;
  endfunction

  // A counter for a single value still needs one bit to exist
  function automatic int cnt_w(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/win_addr_gen_wrap_counter.sv
// wrap_counter -- modulo-MAX up counter used for each scan dimension.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   en         : advance by one this cycle
//   clr        : synchronous return to zero, wins over en
//   count      : current value, 0..MAX-1
//   wrap       : high in the cycle where en moves count from MAX-1 back to 0;
//                used as the enable of the next slower counter
module wrap_counter
  import win_addr_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] r_count;

  assign count = r_count;
  assign wrap  = en && (r_count == W'(MAX - 1));

  // Count on enable, folding back to zero at the top of the range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr || wrap) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/win_addr_gen.sv
// win_addr_gen -- sliding-window address generator. Walks every KxK window
// of an IMG_W x IMG_H image, emitting one window element per beat, with
// LANES lanes each covering an equal band of output rows.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   start        : begin a full scan (only honoured in IDLE)
//   clear        : synchronous abort back to IDLE, beats start and beats
//   out_ready    : consumer takes the current beat
//   out_valid    : addr/kidx hold a beat
//   addr         : LANES packed addresses, lane 0 in the LSBs
//   kidx         : window element index kr*K+kc
//   busy         : scan in progress
//   done         : one-cycle pulse after the final beat
// Optional build macro WIN_ADDR_GEN_LAST_EN adds:
//   win_last     : beat is the last element of a window
//   row_last     : beat is the last element of the last window in a row
module win_addr_gen
  import win_addr_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int LANES  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [LANES*ADDR_W-1:0]   addr,
  output logic [$clog2(K*K)-1:0]    kidx,
  output logic                      busy,
`ifdef WIN_ADDR_GEN_LAST_EN
  output logic                      win_last,
  output logic                      row_last,
`endif
  output logic                      done
);

  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int ROWS  = OUT_H / LANES;
  localparam int KCW   = cnt_w(K);
  localparam int CW    = cnt_w(OUT_W);
  localparam int RW    = cnt_w(ROWS);
  localparam int KIW   = $clog2(K * K);

  if (OUT_H % LANES != 0) begin : g_bad_lanes
    $error("win_addr_gen: output rows must divide evenly across lanes");
  end
  if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_bad_addr
    $error("win_addr_gen: image does not fit in ADDR_W address bits");
  end
  if (K < 2) begin : g_bad_k
    $error("win_addr_gen: window side must be at least 2");
  end

  state_t                  r_state;
  logic [LANES*ADDR_W-1:0] r_addr;
  logic [KIW-1:0]          r_kidx;

  logic           w_beat;
  logic           w_runNext;
  logic [KCW-1:0] w_kc;
  logic [KCW-1:0] w_kr;
  logic [CW-1:0]  w_c;
  logic [RW-1:0]  w_r;
  logic           w_kcWrap;
  logic           w_krWrap;
  logic           w_cWrap;
  logic           w_rWrap;
  int             w_kcNext;
  int             w_krNext;
  int             w_cNext;
  int             w_rNext;
  logic [LANES*ADDR_W-1:0] w_addrNext;

  assign w_beat    = (r_state == ST_RUN) && out_ready;
  assign out_valid = (r_state == ST_RUN);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign addr      = r_addr;
  assign kidx      = r_kidx;

  // Counter chain: each counter's wrap enables the next slower one, so the
  // final beat of the scan is exactly the cycle the row counter wraps
  wrap_counter #(.MAX(K)) u_kc (
    .clk(clk), .reset(reset), .en(w_beat), .clr(clear),
    .count(w_kc), .wrap(w_kcWrap)
  );
  wrap_counter #(.MAX(K)) u_kr (
    .clk(clk), .reset(reset), .en(w_kcWrap), .clr(clear),
    .count(w_kr), .wrap(w_krWrap)
  );
  wrap_counter #(.MAX(OUT_W)) u_c (
    .clk(clk), .reset(reset), .en(w_krWrap), .clr(clear),
    .count(w_c), .wrap(w_cWrap)
  );
  wrap_counter #(.MAX(ROWS)) u_r (
    .clk(clk), .reset(reset), .en(w_cWrap), .clr(clear),
    .count(w_r), .wrap(w_rWrap)
  );

  // Whether the next cycle presents a beat; clear beats everything
  always_comb begin
    w_runNext = 1'b0;
    if (!clear) begin
      if (r_state == ST_IDLE) begin
        w_runNext = start;
      end else if (r_state == ST_RUN) begin
        w_runNext = !w_rWrap;
      end
    end
  end

  // Look ahead to the counter values of the next cycle so the address and
  // index can be registered in step with the counters themselves
  always_comb begin
    w_kcNext   = clear ? 0 : w_kcWrap ? 0 : w_beat   ? int'(w_kc) + 1 : int'(w_kc);
    w_krNext   = clear ? 0 : w_krWrap ? 0 : w_kcWrap ? int'(w_kr) + 1 : int'(w_kr);
    w_cNext    = clear ? 0 : w_cWrap  ? 0 : w_krWrap ? int'(w_c)  + 1 : int'(w_c);
    w_rNext    = clear ? 0 : w_rWrap  ? 0 : w_cWrap  ? int'(w_r)  + 1 : int'(w_r);
    w_addrNext = '0;
    for (int l = 0; l < LANES; l++) begin
      w_addrNext[l*ADDR_W +: ADDR_W] = ADDR_W'(lane_base(l, ROWS, STRIDE, IMG_W)
          + (w_rNext * STRIDE + w_krNext) * IMG_W + w_cNext * STRIDE + w_kcNext);
    end
  end

  // Scan sequencing: IDLE -> RUN on start, RUN -> DONE on the last beat,
  // DONE lasts one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) r_state <= ST_RUN;
        ST_RUN:  if (w_rWrap) r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output registers; parked at zero whenever no beat is being presented
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_kidx <= '0;
    end else if (w_runNext) begin
      r_addr <= w_addrNext;
      r_kidx <= KIW'(w_krNext * K + w_kcNext);
    end else begin
      r_addr <= '0;
      r_kidx <= '0;
    end
  end

`ifdef WIN_ADDR_GEN_LAST_EN
  logic r_winLast;
  logic r_rowLast;

  assign win_last = r_winLast;
  assign row_last = r_rowLast;

  // Window / row boundary flags, aligned with the registered address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_winLast <= 1'b0;
      r_rowLast <= 1'b0;
    end else begin
      r_winLast <= w_runNext && (w_krNext == K - 1) && (w_kcNext == K - 1);
      r_rowLast <= w_runNext && (w_krNext == K - 1) && (w_kcNext == K - 1)
                   && (w_cNext == OUT_W - 1);
    end
  end
`endif

endmodule

// File: tb/tb_win_addr_gen.sv
// tb_win_addr_gen -- directed bench for win_addr_gen.
// Instance A: 28x28 image, K=5, stride 1, four lanes.
// Instance B: 24x24 image, K=2, stride 2, one lane.
module tb_win_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        startA, clearA, readyA, validA, busyA, doneA;
  logic [39:0] addrA;
  logic [4:0]  kidxA;
  logic        startB, clearB, readyB, validB, busyB, doneB;
  logic [9:0]  addrB;
  logic [1:0]  kidxB;

  int compared   = 0;
  int mismatched = 0;
  int doneCntA   = 0;
  int doneCntB   = 0;
  int beatCntA   = 0;
  int beatCntB   = 0;
  int beatSnap;
  int doneSnap;

  always #5 clk = ~clk;

  win_addr_gen #(
    .IMG_W(28), .IMG_H(28), .K(5), .STRIDE(1), .LANES(4), .ADDR_W(10)
  ) dutA (
    .clk(clk), .reset(reset), .start(startA), .clear(clearA),
    .out_ready(readyA), .out_valid(validA), .addr(addrA), .kidx(kidxA),
    .busy(busyA), .done(doneA)
  );

  win_addr_gen #(
    .IMG_W(24), .IMG_H(24), .K(2), .STRIDE(2), .LANES(1), .ADDR_W(10)
  ) dutB (
    .clk(clk), .reset(reset), .start(startB), .clear(clearB),
    .out_ready(readyB), .out_valid(validB), .addr(addrB), .kidx(kidxB),
    .busy(busyB), .done(doneB)
  );

  // Count done pulses and accepted beats as the consumer would see them
  always @(posedge clk) begin
    if (doneA) doneCntA <= doneCntA + 1;
    if (doneB) doneCntB <= doneCntB + 1;
    if (validA && readyA) beatCntA <= beatCntA + 1;
    if (validB && readyB) beatCntB <= beatCntB + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full scan of instance A against the window formula; optionally stalls
  // the consumer for 3 cycles at one beat and pulses start at another
  task automatic applyStimulus(input int stallAt, input int startAt);
    int idx = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 24; c++)
        for (int kr = 0; kr < 5; kr++)
          for (int kc = 0; kc < 5; kc++) begin
            checkOutput("A valid", validA, 1);
            if (idx == 0) checkOutput("A busy", busyA, 1);
            for (int l = 0; l < 4; l++)
              checkOutput("A addr", addrA[l*10 +: 10], l*168 + (r+kr)*28 + c + kc);
            checkOutput("A kidx", kidxA, kr*5 + kc);
            if (idx == stallAt) begin
              readyA = 1'b0;
              repeat (3) begin
                tick();
                checkOutput("A stall valid", validA, 1);
                checkOutput("A stall addr0", addrA[9:0], (r+kr)*28 + c + kc);
                checkOutput("A stall addr3", addrA[39:30], 504 + (r+kr)*28 + c + kc);
                checkOutput("A stall kidx", kidxA, kr*5 + kc);
              end
              readyA = 1'b1;
            end
            if (idx == startAt) startA = 1'b1;
            tick();
            startA = 1'b0;
            idx++;
          end
    checkOutput("A done pulse", doneA, 1);
    checkOutput("A valid at done", validA, 0);
    tick();
    checkOutput("A done after", doneA, 0);
    checkOutput("A busy after", busyA, 0);
  endtask

  initial begin
    logic [39:0] firstA;
    firstA = {10'd504, 10'd336, 10'd168, 10'd0};
    reset = 1'b1;
    startA = 1'b0; clearA = 1'b0; readyA = 1'b1;
    startB = 1'b0; clearB = 1'b0; readyB = 1'b1;
    repeat (2) tick();

    checkOutput("A reset valid", validA, 0);
    checkOutput("A reset busy", busyA, 0);
    checkOutput("A reset done", doneA, 0);
    checkOutput("A reset addr", addrA, 0);
    checkOutput("A reset kidx", kidxA, 0);
    checkOutput("B reset valid", validB, 0);
    checkOutput("B reset addr", addrB, 0);
    reset = 1'b0;
    tick();
    checkOutput("A idle busy", busyA, 0);

    $display("[TB] instance A scan with stall and stray start");
    startA = 1'b1;
    tick();
    startA = 1'b0;
    checkOutput("A first addr", addrA, firstA);
    beatSnap = beatCntA;
    doneSnap = doneCntA;
    applyStimulus(10, 50);
    checkOutput("A beat total", beatCntA - beatSnap, 3600);
    checkOutput("A done count", doneCntA - doneSnap, 1);

    $display("[TB] instance A clear with start at beat 100");
    startA = 1'b1;
    tick();
    startA = 1'b0;
    repeat (100) tick();
    checkOutput("A beat100 addr0", addrA[9:0], 4);
    checkOutput("A beat100 kidx", kidxA, 0);
    doneSnap = doneCntA;
    clearA = 1'b1;
    startA = 1'b1;
    tick();
    clearA = 1'b0;
    startA = 1'b0;
    checkOutput("A clear valid", validA, 0);
    checkOutput("A clear busy", busyA, 0);
    checkOutput("A clear done", doneA, 0);
    checkOutput("A clear addr0", addrA[9:0], 0);
    checkOutput("A clear kidx", kidxA, 0);
    repeat (3) tick();
    checkOutput("A clear no done", doneCntA - doneSnap, 0);
    checkOutput("A clear stays idle", validA, 0);
    startA = 1'b1;
    tick();
    startA = 1'b0;
    checkOutput("A restart valid", validA, 1);
    checkOutput("A restart addr", addrA, firstA);
    checkOutput("A restart kidx", kidxA, 0);

    $display("[TB] instance A reset mid-scan");
    repeat (37) tick();
    checkOutput("A pre-reset kidx", kidxA, 12);
    reset = 1'b1;
    #1;
    checkOutput("A async valid", validA, 0);
    checkOutput("A async busy", busyA, 0);
    checkOutput("A async done", doneA, 0);
    checkOutput("A async addr", addrA, 0);
    checkOutput("A async kidx", kidxA, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("A post-reset valid", validA, 0);
    checkOutput("A reset no done", doneCntA - doneSnap, 0);
    startA = 1'b1;
    tick();
    startA = 1'b0;
    beatSnap = beatCntA;
    applyStimulus(-1, -1);
    checkOutput("A rescan beats", beatCntA - beatSnap, 3600);
    checkOutput("A rescan done", doneCntA - doneSnap, 1);

    $display("[TB] instance B strided 2x2 scan");
    startB = 1'b1;
    tick();
    startB = 1'b0;
    beatSnap = beatCntB;
    doneSnap = doneCntB;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++)
        for (int kr = 0; kr < 2; kr++)
          for (int kc = 0; kc < 2; kc++) begin
            checkOutput("B valid", validB, 1);
            checkOutput("B addr", addrB, (r*2 + kr)*24 + c*2 + kc);
            checkOutput("B kidx", kidxB, kr*2 + kc);
            tick();
          end
    checkOutput("B done pulse", doneB, 1);
    checkOutput("B valid at done", validB, 0);
    tick();
    checkOutput("B busy after", busyB, 0);
    checkOutput("B beat total", beatCntB - beatSnap, 576);
    checkOutput("B done count", doneCntB - doneSnap, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
